instr_exec_register: RTL and testbench
======================================

// Module: instr_exec_register
// PURPOSE
//  Parametrised successor of the lab instruction register: a DEPTH-entry register file of
//  {opcode, operand_a, operand_b, result} records with an integrated execution unit.
//  Single-cycle ops write their result on load; DIV/MOD/POW run on a multi-cycle sequential engine.
//  Per-entry done/err flags; load_ready back-pressure. Sits between the stimulus/TB driver and checker.
// PARAMETERS
//  OP_W   32            operand width (signed)
//  RES_W  2*OP_W        result width (signed)
//  DEPTH  32            number of entries
//  AW     $clog2(DEPTH) pointer width (derived, not overridden)
// PORTS
//  clk            in   1      clock, rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  load_en        in   1      load request
//  load_ready     out  1      engine idle; load accepted when load_en && load_ready
//  write_pointer  in   AW     entry written on accept
//  opcode         in   4      ZERO=0 PASSA=1 PASSB=2 ADD=3 SUB=4 MULT=5 DIV=6 MOD=7 POW=8
//  operand_a      in   OP_W   signed operand A
//  operand_b      in   OP_W   signed operand B
//  read_pointer   in   AW     entry to read
//  rd_opcode      out  4      registered read: opcode
//  rd_op_a        out  OP_W   registered read: operand A
//  rd_op_b        out  OP_W   registered read: operand B
//  rd_res         out  RES_W  registered read: result
//  rd_done        out  1      registered read: result valid
//  rd_err         out  1      registered read: div-by-zero / illegal opcode
//  busy           out  1      multi-cycle op in progress (= ~load_ready)
// BEHAVIOUR
//  Reset: every entry opc=ZERO, ops=0, res=0, done=0, err=0; all rd_* = 0; FSM=IDLE, load_ready=1.
//   Reset mid-operation aborts the engine; no write-back.
//  FSM: IDLE -> RUN (DIV/MOD/POW accepted) -> WB -> IDLE. load_ready=1 only in IDLE.
//  Accept (edge N): entry[wp] <= {opc, a, b}. For single-cycle ops (0-5), res and done=1 written
//   at the same edge. For DIV/MOD/POW: res=0, done=0 at edge N; engine latches a, b, wp.
//  Arithmetic (signed, computed at RES_W, two's-complement wrap):
//   ZERO 0; PASSA sext(a); PASSB sext(b); ADD a+b; SUB a-b; MULT a*b (full product, no overflow).
//   DIV: quotient truncates toward zero. MOD: remainder takes sign of a. Restoring divider on
//    |a|,|b|, one quotient bit per cycle, sign fixup in WB.
//   POW: square-and-multiply, one exponent bit per cycle, LSB first, low RES_W bits kept.
//    b<0 -> res=0 (err=0); b==0 -> res=1 (incl. a==0).
//  Latency: RUN lasts exactly OP_W cycles; WB edge is N+OP_W+1 (entry done=1), load_ready=1
//   after that edge. Fixed regardless of operand values.
//  Errors: DIV/MOD with b==0 -> res=0, err=1, still full latency. Opcode 9-15 -> res=0, err=1,
//   done=1, single-cycle.
//  Read port: rd_* <= entry[read_pointer] each edge (1-cycle latency, no enable). Same-edge
//   write and read of one address returns pre-write contents. Reading an entry in RUN
//   shows its new opc/ops with done=0, res=0.
//  load_en while !load_ready: ignored, nothing written, no queuing. Inputs X while load_en=0 are
//   harmless.
//  Pointers: full AW range legal; if DEPTH < 2**AW, out-of-range write ignored, read returns 0.
// TESTING
//  1 Reset: drive entries, pulse reset_n low mid-DIV -> all rd_* 0, load_ready=1, target done=0.
//  2 ADD a=7 b=-3 wp=2, read rp=2 -> next cycle rd_res=4, rd_done=1; MULT 0x7FFFFFFF*0x7FFFFFFF
//    -> rd_res=0x3FFFFFFF00000001.
//  3 DIV a=-7 b=2 -> res=-3 exactly 33 edges after accept; MOD same -> -1; load_ready low 33
//    cycles; load_en pulses during busy leave entries unchanged.
//  4 DIV a=5 b=0 -> res=0, err=1, done=1 at N+33; opcode 12 -> err=1 next cycle.
//  5 POW a=3 b=5 -> 243; a=-2 b=63 -> low 64 bits of -2^63 = 0x8000000000000000; b=-1 -> 0;
//    a=0 b=0 -> 1.
//  6 Fill all 32 entries random ops, read back every address, compare to SV reference model;
//    include same-cycle write/read of one address -> old data returned.

Source files
------------

// File: rtl/instr_exec_register.sv
// Register file of {opcode, operand_a, operand_b, result} records with an attached execution unit.
// Single-cycle ops resolve on load; DIV/MOD/POW run on a bit-serial engine and write back later.
module instr_exec_register #(
  parameter int OP_W  = 32,
  parameter int RES_W = 2*OP_W,
  parameter int DEPTH = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_en,
  output logic                    load_ready,
  input  logic [AW-1:0]           write_pointer,
  input  logic [3:0]              opcode,
  input  logic signed [OP_W-1:0]  operand_a,
  input  logic signed [OP_W-1:0]  operand_b,
  input  logic [AW-1:0]           read_pointer,
  output logic [3:0]              rd_opcode,
  output logic signed [OP_W-1:0]  rd_op_a,
  output logic signed [OP_W-1:0]  rd_op_b,
  output logic signed [RES_W-1:0] rd_res,
  output logic                    rd_done,
  output logic                    rd_err,
  output logic                    busy
);

  localparam logic [3:0] OPC_ZERO  = 4'd0;
  localparam logic [3:0] OPC_PASSA = 4'd1;
  localparam logic [3:0] OPC_PASSB = 4'd2;
  localparam logic [3:0] OPC_ADD   = 4'd3;
  localparam logic [3:0] OPC_SUB   = 4'd4;
  localparam logic [3:0] OPC_MULT  = 4'd5;
  localparam logic [3:0] OPC_DIV   = 4'd6;
  localparam logic [3:0] OPC_MOD   = 4'd7;
  localparam logic [3:0] OPC_POW   = 4'd8;
  localparam int         CW        = $clog2(OP_W);
  localparam bit         PARTIAL   = (DEPTH < (1 << AW));

  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

  logic [3:0]              opc_mem  [DEPTH];
  logic signed [OP_W-1:0]  a_mem    [DEPTH];
  logic signed [OP_W-1:0]  b_mem    [DEPTH];
  logic signed [RES_W-1:0] res_mem  [DEPTH];
  logic                    done_mem [DEPTH];
  logic                    err_mem  [DEPTH];

  state_t            state_reg;
  logic              load_ready_reg;
  logic [CW-1:0]     cnt_reg;
  logic [3:0]        eng_op_reg;
  logic [AW-1:0]     eng_wp_reg;
  logic              sign_a_reg;
  logic              sign_b_reg;
  logic              b_zero_reg;
  logic [OP_W-1:0]   q_reg;
  logic [OP_W-1:0]   rem_reg;
  logic [OP_W-1:0]   dvs_reg;
  logic [OP_W-1:0]   exp_reg;
  logic [RES_W-1:0]  acc_reg;
  logic [RES_W-1:0]  base_reg;

  logic                    accept;
  logic                    wb_en;
  logic [DEPTH-1:0]        we_vec;
  logic [DEPTH-1:0]        wb_vec;
  logic signed [RES_W-1:0] a_ext;
  logic signed [RES_W-1:0] b_ext;
  logic signed [RES_W-1:0] sc_res;
  logic                    sc_err;
  logic                    is_multi;
  logic [OP_W-1:0]         a_mag;
  logic [OP_W-1:0]         b_mag;
  logic [OP_W:0]           rem_shift;
  logic [OP_W-1:0]         rem_diff;
  logic                    rem_ge;
  logic [RES_W-1:0]        q_ext;
  logic [RES_W-1:0]        r_ext;
  logic [RES_W-1:0]        wb_res;
  logic                    wb_err;
  logic                    rd_in_range;

  assign load_ready = load_ready_reg;
  assign busy       = ~load_ready_reg;
  assign accept     = load_en && load_ready_reg;
  assign wb_en      = (state_reg == WB);

  // Out-of-range pointers simply match no entry, so such writes vanish.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_sel
      assign we_vec[gi] = accept && (write_pointer == AW'(gi));
      assign wb_vec[gi] = wb_en && (eng_wp_reg == AW'(gi));
    end
    if (PARTIAL) begin : g_rd_range
      assign rd_in_range = ({1'b0, read_pointer} < (AW+1)'(DEPTH));
    end else begin : g_rd_full
      assign rd_in_range = 1'b1;
    end
  endgenerate

  always_comb begin
    a_ext    = {{(RES_W-OP_W){operand_a[OP_W-1]}}, operand_a};
    b_ext    = {{(RES_W-OP_W){operand_b[OP_W-1]}}, operand_b};
    a_mag    = operand_a[OP_W-1] ? -operand_a : operand_a;
    b_mag    = operand_b[OP_W-1] ? -operand_b : operand_b;
    sc_res   = '0;
    sc_err   = 1'b0;
    is_multi = 1'b0;
    case (opcode)
      OPC_ZERO:  sc_res = '0;
      OPC_PASSA: sc_res = a_ext;
      OPC_PASSB: sc_res = b_ext;
      OPC_ADD:   sc_res = a_ext + b_ext;
      OPC_SUB:   sc_res = a_ext - b_ext;
      OPC_MULT:  sc_res = a_ext * b_ext;
      OPC_DIV, OPC_MOD, OPC_POW: is_multi = 1'b1;
      default:   sc_err = 1'b1;
    endcase
  end

  // Restoring divider step: the true difference is below the divisor, so OP_W bits suffice.
  always_comb begin
    rem_shift = {rem_reg, q_reg[OP_W-1]};
    rem_ge    = (rem_shift >= {1'b0, dvs_reg});
    rem_diff  = {rem_reg[OP_W-2:0], q_reg[OP_W-1]} - dvs_reg;
  end

  always_comb begin
    q_ext  = {{(RES_W-OP_W){1'b0}}, q_reg};
    r_ext  = {{(RES_W-OP_W){1'b0}}, rem_reg};
    wb_res = '0;
    wb_err = 1'b0;
    case (eng_op_reg)
      OPC_DIV: begin
        if (b_zero_reg) wb_err = 1'b1;
        else            wb_res = (sign_a_reg ^ sign_b_reg) ? -q_ext : q_ext;
      end
      OPC_MOD: begin
        if (b_zero_reg) wb_err = 1'b1;
        else            wb_res = sign_a_reg ? -r_ext : r_ext;
      end
      default: wb_res = sign_b_reg ? '0 : acc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      load_ready_reg <= 1'b1;
      cnt_reg        <= '0;
      eng_op_reg     <= OPC_ZERO;
      eng_wp_reg     <= '0;
      sign_a_reg     <= 1'b0;
      sign_b_reg     <= 1'b0;
      b_zero_reg     <= 1'b0;
      q_reg          <= '0;
      rem_reg        <= '0;
      dvs_reg        <= '0;
      exp_reg        <= '0;
      acc_reg        <= '0;
      base_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && is_multi) begin
            state_reg      <= RUN;
            load_ready_reg <= 1'b0;
            cnt_reg        <= '0;
            eng_op_reg     <= opcode;
            eng_wp_reg     <= write_pointer;
            sign_a_reg     <= operand_a[OP_W-1];
            sign_b_reg     <= operand_b[OP_W-1];
            b_zero_reg     <= (operand_b == '0);
            q_reg          <= a_mag;
            rem_reg        <= '0;
            dvs_reg        <= b_mag;
            exp_reg        <= operand_b;
            acc_reg        <= RES_W'(1);
            base_reg       <= a_ext;
          end
        end
        RUN: begin
          // Divider and power engine both step every cycle; WB picks the one that matters.
          q_reg   <= {q_reg[OP_W-2:0], rem_ge};
          rem_reg <= rem_ge ? rem_diff : rem_shift[OP_W-1:0];
          if (exp_reg[0]) acc_reg <= acc_reg * base_reg;
          base_reg <= base_reg * base_reg;
          exp_reg  <= exp_reg >> 1;
          cnt_reg  <= cnt_reg + CW'(1);
          if (cnt_reg == CW'(OP_W-1)) state_reg <= WB;
        end
        default: begin
          state_reg      <= IDLE;
          load_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_mem[i]  <= OPC_ZERO;
        a_mem[i]    <= '0;
        b_mem[i]    <= '0;
        res_mem[i]  <= '0;
        done_mem[i] <= 1'b0;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_vec[i]) begin
          opc_mem[i]  <= opcode;
          a_mem[i]    <= operand_a;
          b_mem[i]    <= operand_b;
          res_mem[i]  <= is_multi ? '0 : sc_res;
          done_mem[i] <= ~is_multi;
          err_mem[i]  <= is_multi ? 1'b0 : sc_err;
        end else if (wb_vec[i]) begin
          res_mem[i]  <= wb_res;
          done_mem[i] <= 1'b1;
          err_mem[i]  <= wb_err;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_opcode <= '0;
      rd_op_a   <= '0;
      rd_op_b   <= '0;
      rd_res    <= '0;
      rd_done   <= 1'b0;
      rd_err    <= 1'b0;
    end else if (rd_in_range) begin
      rd_opcode <= opc_mem[read_pointer];
      rd_op_a   <= a_mem[read_pointer];
      rd_op_b   <= b_mem[read_pointer];
      rd_res    <= res_mem[read_pointer];
      rd_done   <= done_mem[read_pointer];
      rd_err    <= err_mem[read_pointer];
    end else begin
      rd_opcode <= '0;
      rd_op_a   <= '0;
      rd_op_b   <= '0;
      rd_res    <= '0;
      rd_done   <= 1'b0;
      rd_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_exec_register.sv
// Directed bench for instr_exec_register: hand-computed vectors plus a reference model for a random fill.
module tb_instr_exec_register;

  localparam logic [3:0] ZERO = 4'd0, PASSA = 4'd1, PASSB = 4'd2, ADD = 4'd3, SUB = 4'd4;
  localparam logic [3:0] MULT = 4'd5, DIV = 4'd6, MOD = 4'd7, POW = 4'd8;

  logic               clk;
  logic               reset_n;
  logic               load_en;
  logic               load_ready;
  logic [4:0]         write_pointer;
  logic [3:0]         opcode;
  logic signed [31:0] operand_a;
  logic signed [31:0] operand_b;
  logic [4:0]         read_pointer;
  logic [3:0]         rd_opcode;
  logic signed [31:0] rd_op_a;
  logic signed [31:0] rd_op_b;
  logic signed [63:0] rd_res;
  logic               rd_done;
  logic               rd_err;
  logic               busy;

  int checks;
  int errors;

  logic [3:0] exp_opc  [32];
  int         exp_a    [32];
  int         exp_b    [32];
  longint     exp_res  [32];
  bit         exp_done [32];
  bit         exp_err  [32];

  instr_exec_register dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_ready(load_ready),
    .write_pointer(write_pointer), .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_pointer(read_pointer), .rd_opcode(rd_opcode), .rd_op_a(rd_op_a), .rd_op_b(rd_op_b),
    .rd_res(rd_res), .rd_done(rd_done), .rd_err(rd_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic void ref_model(input logic [3:0] op, input int a, input int b,
                                    output longint r, output bit e);
    longint a64 = a;
    longint b64 = b;
    r = 0;
    e = 1'b0;
    case (op)
      ZERO:  r = 0;
      PASSA: r = a64;
      PASSB: r = b64;
      ADD:   r = a64 + b64;
      SUB:   r = a64 - b64;
      MULT:  r = a64 * b64;
      DIV:   if (b == 0) e = 1'b1; else r = a64 / b64;
      MOD:   if (b == 0) e = 1'b1; else r = a64 % b64;
      POW: begin
        if (b >= 0) begin
          r = 1;
          for (int k = 0; k < b; k++) r = r * a64;
        end
      end
      default: e = 1'b1;
    endcase
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 32; i++) begin
      exp_opc[i] = ZERO; exp_a[i] = 0; exp_b[i] = 0;
      exp_res[i] = 0; exp_done[i] = 1'b0; exp_err[i] = 1'b0;
    end
  endfunction

  task automatic load(input logic [3:0] op, input int a, input int b, input int wp);
    int guard;
    longint r;
    bit e;
    guard = 0;
    while (!load_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) chk("ready_timeout", 64'(guard), 64'd0);
    load_en = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = 5'(wp);
    $display("LOAD op=%0d a=%0d b=%0d wp=%0d", op, a, b, wp);
    @(posedge clk); #1;
    load_en = 1'b0;
    ref_model(op, a, b, r, e);
    exp_opc[wp] = op; exp_a[wp] = a; exp_b[wp] = b;
    exp_res[wp] = r; exp_err[wp] = e; exp_done[wp] = 1'b1;
  endtask

  // Counts edges until the engine is idle; optionally fires ignored loads at entry 10 meanwhile.
  task automatic wait_idle(input bit pulse, output int n);
    n = 0;
    while (!load_ready && n < 200) begin
      if (pulse && (n % 4 == 1)) begin
        load_en = 1'b1; opcode = ADD; write_pointer = 5'd10; operand_a = 1; operand_b = 1;
      end else begin
        load_en = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    load_en = 1'b0;
  endtask

  task automatic rd(input int rp);
    read_pointer = 5'(rp);
    @(posedge clk); #1;
    $display("READ rp=%0d opc=%0d res=%h done=%0d err=%0d", rp, rd_opcode, rd_res, rd_done, rd_err);
  endtask

  task automatic check_entry(input int i);
    rd(i);
    chk($sformatf("e%0d_opc", i),  64'(rd_opcode), 64'(exp_opc[i]));
    chk($sformatf("e%0d_a", i),    64'(rd_op_a),   64'(exp_a[i]));
    chk($sformatf("e%0d_b", i),    64'(rd_op_b),   64'(exp_b[i]));
    chk($sformatf("e%0d_res", i),  rd_res,         exp_res[i]);
    chk($sformatf("e%0d_done", i), 64'(rd_done),   64'(exp_done[i]));
    chk($sformatf("e%0d_err", i),  64'(rd_err),    64'(exp_err[i]));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] op;
    int a, b;
    longint old_res;
    logic [3:0] old_opc;

    checks = 0; errors = 0;
    reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; opcode = '0;
    operand_a = '0; operand_b = '0; read_pointer = '0;
    clear_model();
    repeat (3) @(posedge clk); #1;
    chk("rst_ready",  64'(load_ready), 64'd1);
    chk("rst_busy",   64'(busy),       64'd0);
    chk("rst_rd_res", rd_res,          64'd0);
    chk("rst_rd_done", 64'(rd_done),   64'd0);
    reset_n = 1'b1;

    // Reset in the middle of a DIV aborts it
    load(ADD, 1, 2, 1);
    load(DIV, 100, 7, 5);
    repeat (5) @(posedge clk); #1;
    chk("t1_busy_mid", 64'(busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_rd_res",   rd_res,            64'd0);
    chk("t1_rd_opc",   64'(rd_opcode),    64'd0);
    chk("t1_rd_a",     64'(rd_op_a),      64'd0);
    chk("t1_ready",    64'(load_ready),   64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_model();
    rd(5);
    chk("t1_e5_done", 64'(rd_done),   64'd0);
    chk("t1_e5_opc",  64'(rd_opcode), 64'd0);
    rd(1);
    chk("t1_e1_res",  rd_res,         64'd0);
    repeat (40) @(posedge clk); #1;
    rd(5);
    chk("t1_e5_nowb", 64'(rd_done),   64'd0);

    // Single-cycle arithmetic
    load(ADD, 7, -3, 2);
    rd(2);
    chk("t2_add_res",  rd_res,          64'd4);
    chk("t2_add_done", 64'(rd_done),    64'd1);
    chk("t2_add_err",  64'(rd_err),     64'd0);
    load(MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 3);
    rd(3);
    chk("t2_mult_res", rd_res, 64'h3FFF_FFFF_0000_0001);
    load(SUB, -5, 10, 11);
    rd(11);
    chk("t2_sub_res",  rd_res, 64'hFFFF_FFFF_FFFF_FFF1);

    // Multi-cycle latency and ignored loads while busy
    load(PASSA, 55, 0, 10);
    load(DIV, -7, 2, 4);
    read_pointer = 5'd4;
    wait_idle(1'b1, n);
    chk("t3_div_lat",   64'(n),         64'd33);
    chk("t3_run_done",  64'(rd_done),   64'd0);
    chk("t3_run_opc",   64'(rd_opcode), 64'd6);
    chk("t3_run_res",   rd_res,         64'd0);
    @(posedge clk); #1;
    chk("t3_div_res",   rd_res,         64'hFFFF_FFFF_FFFF_FFFD);
    chk("t3_div_done",  64'(rd_done),   64'd1);
    rd(10);
    chk("t3_busy_ign_res", rd_res,         64'd55);
    chk("t3_busy_ign_opc", 64'(rd_opcode), 64'd1);
    load(MOD, -7, 2, 4);
    wait_idle(1'b0, n);
    chk("t3_mod_lat",   64'(n), 64'd33);
    rd(4);
    chk("t3_mod_res",   rd_res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Error cases
    load(DIV, 5, 0, 6);
    wait_idle(1'b0, n);
    chk("t4_dz_lat",  64'(n), 64'd33);
    rd(6);
    chk("t4_dz_res",  rd_res,        64'd0);
    chk("t4_dz_err",  64'(rd_err),   64'd1);
    chk("t4_dz_done", 64'(rd_done),  64'd1);
    load(4'd12, 1, 2, 7);
    rd(7);
    chk("t4_ill_err",  64'(rd_err),  64'd1);
    chk("t4_ill_done", 64'(rd_done), 64'd1);
    chk("t4_ill_res",  rd_res,       64'd0);

    // Power
    load(POW, 3, 5, 8);
    wait_idle(1'b0, n);
    rd(8);
    chk("t5_pow_3_5", rd_res, 64'd243);
    load(POW, -2, 63, 8);
    wait_idle(1'b0, n);
    rd(8);
    chk("t5_pow_m2_63", rd_res, 64'h8000_0000_0000_0000);
    load(POW, 5, -1, 8);
    wait_idle(1'b0, n);
    rd(8);
    chk("t5_pow_bneg", rd_res,       64'd0);
    chk("t5_pow_err",  64'(rd_err),  64'd0);
    load(POW, 0, 0, 8);
    wait_idle(1'b0, n);
    rd(8);
    chk("t5_pow_0_0", rd_res, 64'd1);

    // Random fill of every entry against the reference model
    for (int i = 0; i < 32; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = $urandom;
      if (op == POW) begin
        a = $urandom_range(0, 10) - 5;
        b = $urandom_range(0, 20);
        if ($urandom_range(0, 5) == 0) b = -$urandom_range(1, 9);
      end
      if ((op == DIV || op == MOD) && $urandom_range(0, 3) == 0) b = 0;
      load(op, a, b, i);
    end
    wait_idle(1'b0, n);
    for (int i = 0; i < 32; i++) check_entry(i);

    // Same-edge write and read of one address returns the old contents
    old_res = exp_res[9];
    old_opc = exp_opc[9];
    read_pointer = 5'd9;
    load(ADD, 11, 22, 9);
    chk("t6_same_res", rd_res,         old_res);
    chk("t6_same_opc", 64'(rd_opcode), 64'(old_opc));
    check_entry(9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
